// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one physical memory port between the instruction-side (i_*) and
// data-side (d_*) caches. One transaction is granted at a time. Ties are
// broken round-robin. The winner's command is latched on the grant edge, and
// the memory response strobe is steered back to the winner only.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   i_read, i_write     instruction-side request strobes (held until i_resp)
//   i_address, i_wdata  instruction-side command
//   i_rdata, i_resp     instruction-side read data and completion pulse
//   d_*                 same set for the data side
//   mem_read/mem_write  downstream request strobes
//   mem_address/wdata   downstream command (from captured registers)
//   mem_rdata, mem_resp downstream read data and completion pulse

module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_resp,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // 1 when the data side received the most recent grant, 0 for instruction side.
    logic last_grant_d;

    // Command captured on the grant edge; the memory port is driven only from here.
    logic              op_write;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic i_pending;
    logic d_pending;
    logic grant_i;
    logic grant_d;

    assign i_pending = i_read | i_write;
    assign d_pending = d_read | d_write;

    // State register. The async reset forces IDLE immediately, which takes the
    // memory strobes down in the same cycle because they decode from state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state, grant decision and output decode.
    // Grants are only issued from IDLE, so every transaction is followed by at
    // least one IDLE cycle. That gap lets a requester drop its strobes after
    // its resp before it can be considered again.
    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;

        case (state)
            IDLE: begin
                if (i_pending && d_pending) begin
                    if (last_grant_d) begin
                        grant_i = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                    end
                end else if (i_pending) begin
                    grant_i = 1'b1;
                end else if (d_pending) begin
                    grant_d = 1'b1;
                end

                if (grant_i) begin
                    next_state = GRANT_I;
                end else if (grant_d) begin
                    next_state = GRANT_D;
                end
            end

            GRANT_I: begin
                mem_read  = ~op_write;
                mem_write = op_write;
                i_resp    = mem_resp;
                if (mem_resp) begin
                    next_state = IDLE;
                end
            end

            GRANT_D: begin
                mem_read  = ~op_write;
                mem_write = op_write;
                d_resp    = mem_resp;
                if (mem_resp) begin
                    next_state = IDLE;
                end
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Command capture and round-robin history. Write takes priority when a
    // requester raises both strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_d <= 1'b0;
            op_write     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (grant_d) begin
            last_grant_d <= 1'b1;
            op_write     <= d_write;
            addr_q       <= d_address;
            wdata_q      <= d_wdata;
        end else if (grant_i) begin
            last_grant_d <= 1'b0;
            op_write     <= i_write;
            addr_q       <= i_address;
            wdata_q      <= i_wdata;
        end
    end

    assign mem_address = addr_q;
    assign mem_wdata   = wdata_q;

    // Read data goes to both sides unconditionally; only the resp strobes are steered.
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. Each request that is driven
// pushes the downstream command it should produce onto a scoreboard queue.
// A monitor pops one entry on every new grant seen at the memory port and
// compares op, address and write data. The grant order is therefore checked
// through the expected addresses.

module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;

    logic              clk;
    logic              reset;
    logic              i_read, i_write;
    logic [ADDR_W-1:0] i_address;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read, d_write;
    logic [ADDR_W-1:0] d_address;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_resp;
    logic              mem_read, mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_resp;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    logic prev_strobe = 1'b0;

    localparam logic [DATA_W-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [DATA_W-1:0] PAT_W1 = {8{32'h1234_5678}};
    localparam logic [DATA_W-1:0] PAT_W2 = {8{32'hCAFE_F00D}};

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_read     (i_read),
        .i_write    (i_write),
        .i_address  (i_address),
        .i_wdata    (i_wdata),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_address  (d_address),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] actual,
                               input logic [DATA_W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Move to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one requester and record the command the memory port should carry.
    task automatic applyStimulus(input logic side_d, input logic wr,
                                 input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
        exp_t e;
        if (side_d) begin
            d_read = ~wr; d_write = wr; d_address = addr; d_wdata = wdata;
        end else begin
            i_read = ~wr; i_write = wr; i_address = addr; i_wdata = wdata;
        end
        e.wr = wr; e.addr = addr; e.wdata = wdata;
        sb.push_back(e);
    endtask

    task automatic applyReset();
        reset = 1'b1;
        i_read = 0; i_write = 0; i_address = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
        mem_resp = 0; mem_rdata = '0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    // Returns the number of edges until a memory strobe appears, or -1 on timeout.
    task automatic waitGrant(output int n);
        bit got;
        got = 0;
        n = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            if (mem_read | mem_write) got = 1;
            else begin
                step();
                n++;
            end
        end
        if (!got) begin
            checkOutput("grant_timeout", 0, 1);
            n = -1;
        end
    endtask

    // Memory model: answer after 'latency' edges and check the steered response.
    task automatic respond(input int latency, input logic exp_d, input logic [DATA_W-1:0] rdata);
        repeat (latency) step();
        mem_resp = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        checkOutput("d_resp", d_resp, exp_d);
        checkOutput("i_resp", i_resp, !exp_d);
        checkOutput("rdata", exp_d ? d_rdata : i_rdata, rdata);
        step();
        mem_resp = 1'b0;
        mem_rdata = '0;
    endtask

    // Monitor: every rising memory strobe is a new grant and must match the scoreboard head.
    always @(negedge clk) begin
        if (!reset && (mem_read | mem_write) && !prev_strobe) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_grant", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("grant_op_write", mem_write, e.wr);
                checkOutput("grant_op_read", mem_read, !e.wr);
                checkOutput("grant_addr", mem_address, e.addr);
                checkOutput("grant_wdata", mem_wdata, e.wdata);
            end
        end
        prev_strobe <= mem_read | mem_write;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1;
        i_read = 0; i_write = 0; i_address = '0; i_wdata = '0;
        d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
        mem_resp = 0; mem_rdata = '0;

        // Reset state
        @(negedge clk);
        checkOutput("rst_mem_read", mem_read, 0);
        checkOutput("rst_mem_write", mem_write, 0);
        checkOutput("rst_mem_address", mem_address, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 0);
        checkOutput("rst_i_resp", i_resp, 0);
        checkOutput("rst_d_resp", d_resp, 0);
        applyReset();

        // Single D read with 5-cycle memory latency
        applyStimulus(1, 0, 32'h0000_1000, '0);
        waitGrant(n);
        checkOutput("single_latency", n, 1);
        respond(5, 1, PAT_A5);
        d_read = 0;
        @(negedge clk);
        checkOutput("single_back_idle", mem_read | mem_write, 0);
        step();

        // Simultaneous requests after reset: D wins the first tie
        applyReset();
        applyStimulus(1, 1, 32'h80, PAT_W1);
        applyStimulus(0, 0, 32'h40, '0);
        waitGrant(n);
        checkOutput("tie_latency", n, 1);
        respond(3, 1, PAT_W2);
        d_write = 0;
        waitGrant(n);
        checkOutput("tie_turnaround", n, 1);
        respond(2, 0, PAT_A5);
        i_read = 0;
        step();

        // Continuous contention: strict D, I, D, I, D, I alternation
        applyReset();
        i_read = 1; i_address = 32'h300; i_wdata = '0;
        d_read = 1; d_address = 32'h400; d_wdata = '0;
        for (int k = 0; k < 6; k++) begin
            exp_t e;
            e.wr = 0;
            e.addr = (k % 2 == 0) ? 32'h400 : 32'h300;
            e.wdata = '0;
            sb.push_back(e);
        end
        for (int k = 0; k < 6; k++) begin
            waitGrant(n);
            checkOutput("rr_turnaround", n, 1);
            respond(1 + k, (k % 2 == 0), {8{k[31:0]}});
        end
        i_read = 0; d_read = 0;
        step();

        // Capture stability: live input changes during the grant are ignored
        applyStimulus(1, 1, 32'h100, PAT_W1);
        waitGrant(n);
        step();
        d_address = 32'h200;
        d_wdata = ~PAT_W1;
        d_write = 0;
        d_read = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("hold_addr", mem_address, 32'h100);
            checkOutput("hold_wdata", mem_wdata, PAT_W1);
            checkOutput("hold_write", mem_write, 1);
            step();
        end
        respond(1, 1, PAT_A5);
        d_read = 0;
        step();

        // Reset mid-grant, then a stray resp from the aborted access
        applyStimulus(1, 1, 32'h500, PAT_W2);
        waitGrant(n);
        step();
        step();
        reset = 1'b1;
        #1;
        checkOutput("midrst_write_drop", mem_write, 0);
        checkOutput("midrst_addr_clear", mem_address, 0);
        d_write = 0;
        step();
        reset = 1'b0;
        step();
        mem_resp = 1'b1;
        mem_rdata = PAT_A5;
        @(negedge clk);
        checkOutput("stray_d_resp", d_resp, 0);
        checkOutput("stray_i_resp", i_resp, 0);
        step();
        mem_resp = 1'b0;
        @(negedge clk);
        checkOutput("stray_stays_idle", mem_read | mem_write, 0);
        step();

        // Unsolicited resp in IDLE, then confirm the arbiter still grants normally
        mem_resp = 1'b1;
        @(negedge clk);
        checkOutput("unsol_d_resp", d_resp, 0);
        checkOutput("unsol_i_resp", i_resp, 0);
        step();
        mem_resp = 1'b0;
        @(negedge clk);
        checkOutput("unsol_idle", mem_read | mem_write, 0);
        step();
        applyStimulus(0, 0, 32'h40, '0);
        waitGrant(n);
        checkOutput("unsol_then_grant", n, 1);
        respond(2, 0, PAT_W1);
        i_read = 0;
        step();

        checkOutput("scoreboard_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
